// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period helper.
// Used by uart_rx and by the transmitter, so both agree on timing.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK,
      PARITY
   } uart_rx_state_t;

   function automatic int bit_period(input int clk_freq, input int bitrate);
      return clk_freq / bitrate;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input.
// Ports: clk, rst (sync, active-high), d (async in), q (synced out).
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= RST_VAL;
         q  <= RST_VAL;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, W_DATA data bits LSB first, one stop bit; idle high.
// Ports: clk, rst (sync, active-high), rx (async serial in), data (last good
// word), rx_valid (1-cycle strobe), rx_busy (frame in progress), frame_err
// (1-cycle strobe, stop bit low). Optional macro UART_RX_PARITY_EN adds an
// even-parity bit before the stop bit and a parity_err strobe output.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQUENCY = 50_000_000,
   parameter int BITRATE       = 115_200,
   parameter int W_DATA        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic [W_DATA-1:0] data,
   output logic              rx_valid,
   output logic              rx_busy,
`ifdef UART_RX_PARITY_EN
   output logic              parity_err,
`endif
   output logic              frame_err
);

   localparam int BIT_PERIOD  = bit_period(CLK_FREQUENCY, BITRATE);
   localparam int HALF_PERIOD = BIT_PERIOD / 2;
   localparam int W_CNT       = $clog2(BIT_PERIOD);
   localparam int W_BIT       = $clog2(W_DATA + 1);

   localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(BIT_PERIOD - 1);
   localparam logic [W_CNT-1:0] CNT_HALF = W_CNT'(HALF_PERIOD - 1);
   localparam logic [W_BIT-1:0] BIT_LAST = W_BIT'(W_DATA - 1);

   if (BIT_PERIOD < 4) begin : g_chk
      $error("uart_rx: BIT_PERIOD must be >= 4");
   end

   uart_rx_state_t    state, state_nxt;
   logic [W_CNT-1:0]  cnt;
   logic [W_BIT-1:0]  bit_cnt;
   logic [W_DATA-1:0] shreg;
   logic              rx_s;
   logic              shift;
   logic              load;
   logic              valid_nxt;
   logic              ferr_nxt;
`ifdef UART_RX_PARITY_EN
   logic              par_bit;
   logic              par_ld;
   logic              perr_nxt;
`endif

   uart_sync #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   assign rx_busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      shift     = 1'b0;
      load      = 1'b0;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ld    = 1'b0;
      perr_nxt  = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (!rx_s) state_nxt = START;
         end
         START: begin
            // mid-start-bit recheck rejects short glitches
            if (cnt == CNT_HALF) state_nxt = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               shift = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (bit_cnt == BIT_LAST) state_nxt = PARITY;
`else
               if (bit_cnt == BIT_LAST) state_nxt = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == CNT_LAST) begin
               par_ld    = 1'b1;
               state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            // leave on the stop sample so a back-to-back start is caught
            if (cnt == CNT_LAST) begin
               if (rx_s) begin
                  state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (^{shreg, par_bit}) begin
                     perr_nxt = 1'b1;
                  end else begin
                     valid_nxt = 1'b1;
                     load      = 1'b1;
                  end
`else
                  valid_nxt = 1'b1;
                  load      = 1'b1;
`endif
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         data      <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (state_nxt != state || cnt == CNT_LAST) cnt <= '0;
         else                                       cnt <= cnt + 1'b1;
         if (state_nxt != state) bit_cnt <= '0;
         else if (shift)         bit_cnt <= bit_cnt + 1'b1;
         if (shift) shreg <= {rx_s, shreg[W_DATA-1:1]};
         if (load)  data  <= shreg;
         rx_valid  <= valid_nxt;
         frame_err <= ferr_nxt;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (par_ld) par_bit <= rx_s;
         parity_err <= perr_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus directed sequences
// for glitch rejection, back-to-back frames and mid-frame reset.
module tb_uart_rx;

   localparam int CLK_FREQUENCY = 1_000_000;
   localparam int BITRATE       = 100_000;
   localparam int BP            = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_FREQUENCY (CLK_FREQUENCY),
      .BITRATE       (BITRATE),
      .W_DATA        (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .rx_valid  (rx_valid),
      .rx_busy   (rx_busy),
`ifdef UART_RX_PARITY_EN
      .parity_err(parity_err),
`endif
      .frame_err (frame_err)
   );

   int errs   = 0;
   int checks = 0;

   int       vcnt = 0;
   int       fcnt = 0;
   int       bcnt = 0;
   int       acnt = 0;
   int       ovl  = 0;
   logic [7:0] last_d = '0;
   logic [7:0] prev_d = '0;
   time      t_valid = 0;
   time      t_fall  = 0;

   always @(negedge clk) begin
      if (rx_valid) begin
         vcnt    <= vcnt + 1;
         prev_d  <= last_d;
         last_d  <= data;
         t_valid <= $time;
      end
      if (frame_err) fcnt <= fcnt + 1;
      if (rx_busy) bcnt <= bcnt + 1;
      if (rx_valid && frame_err) ovl <= ovl + 1;
      if (rx_valid || rx_busy || frame_err || data != 8'h00)
         acnt <= acnt + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act,
                          input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (BP) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      t_fall = $time;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   typedef struct {
      logic [7:0] din;
      logic       stop;
      int         nvalid;
      int         nferr;
      logic [7:0] dexp;
   } vec_t;

   vec_t vt[6];

   initial begin
      int v0, f0, b0, a0, lat;
      logic [7:0] pat;

      vt[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
      vt[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
      vt[2] = '{8'h01, 1'b1, 1, 0, 8'h01};
      vt[3] = '{8'h80, 1'b1, 1, 0, 8'h80};
      vt[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
      vt[5] = '{8'h00, 1'b0, 0, 1, 8'hFF};

      // reset, then idle line
      repeat (5) @(negedge clk);
      rst = 1'b0;
      a0  = acnt;
      repeat (200) @(negedge clk);
      chk("idle_activity", acnt - a0, 0);
      chk("idle_data", data, 8'h00);
      chk("idle_busy", rx_busy, 0);

      // table of frames
      foreach (vt[k]) begin
         v0 = vcnt;
         f0 = fcnt;
         send_frame(vt[k].din, vt[k].stop);
         if (!vt[k].stop) begin
            rx = 1'b0;
            repeat (20) @(negedge clk);
            chk($sformatf("v%0d_break_busy", k), rx_busy, 1);
            repeat (10) @(negedge clk);
            rx = 1'b1;
         end
         repeat (20) @(negedge clk);
         chk($sformatf("v%0d_valid", k), vcnt - v0, vt[k].nvalid);
         chk($sformatf("v%0d_ferr", k), fcnt - f0, vt[k].nferr);
         chk($sformatf("v%0d_data", k), data, vt[k].dexp);
         chk($sformatf("v%0d_idle", k), rx_busy, 0);
         if (k == 0) begin
            lat = int'((t_valid - t_fall) / 10);
            chk_rng("latency", lat, 97, 99);
         end
      end

      // short low glitch
      v0 = vcnt;
      f0 = fcnt;
      b0 = bcnt;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch_busy_seen", int'(bcnt > b0), 1);
      chk("glitch_valid", vcnt - v0, 0);
      chk("glitch_ferr", fcnt - f0, 0);
      chk("glitch_idle", rx_busy, 0);

      // back-to-back frames, no idle gap
      v0 = vcnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      repeat (20) @(negedge clk);
      chk("b2b_count", vcnt - v0, 2);
      chk("b2b_first", prev_d, 8'h00);
      chk("b2b_second", last_d, 8'hFF);

      // reset during data bit 4
      v0  = vcnt;
      pat = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(pat[i]);
      rx = pat[4];
      repeat (3) @(negedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_data", data, 8'h00);
      chk("rst_valid", rx_valid, 0);
      chk("rst_busy", rx_busy, 0);
      chk("rst_ferr", frame_err, 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_no_partial", vcnt - v0, 0);
      send_frame(8'h5A, 1'b1);
      repeat (20) @(negedge clk);
      chk("post_rst_valid", vcnt - v0, 1);
      chk("post_rst_data", data, 8'h5A);

      chk("valid_ferr_overlap", ovl, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1-style frames (start bit, W_DATA data bits LSB first, one stop bit), line idles high.
- Converts the serial `rx` line into parallel words, with a one-cycle valid strobe per frame.
- Counterpart of the team's UART transmitter: same CLK_FREQUENCY/BITRATE parameterisation and bit-period arithmetic, so a TX→RX loopback works with identical parameters.

Parameters:
- CLK_FREQUENCY, 50_000_000, system clock in Hz.
- BITRATE, 115_200, line rate in bit/s.
- W_DATA, 8, data bits per frame.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  serial line, asynchronous to clk, idle high.
- data  out  W_DATA  last correctly received word.
- rx_valid  out  1  one-cycle strobe; data is new on this cycle.
- rx_busy  out  1  high while a frame is in progress.
- frame_err  out  1  one-cycle strobe; stop bit sampled low.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Constants:
  - BIT_PERIOD = CLK_FREQUENCY / BITRATE (integer division).
  - HALF_PERIOD = BIT_PERIOD / 2.
  - Elaboration-time check: BIT_PERIOD >= 4.
  - Period counter width = $clog2(BIT_PERIOD); bit counter width = $clog2(W_DATA+1).
- Input sync: rx passes through 2 flops (rx_s); both flops reset to 1. All decisions use rx_s only.
- Reset values: data=0, rx_valid=0, rx_busy=0, frame_err=0, state=IDLE, counters=0.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_s==0 -> START, period counter cleared.
  - rx_busy=0 here only.
- START:
  - Count HALF_PERIOD cycles, then sample rx_s.
  - rx_s==0 -> DATA, counter cleared.
  - rx_s==1 -> glitch, back to IDLE; no strobe.
- DATA:
  - Every BIT_PERIOD cycles sample rx_s and shift into a shift register from the MSB side, so the first bit lands at bit 0.
  - After W_DATA samples -> STOP.
- STOP (stop bit sampled BIT_PERIOD cycles after the last data sample):
  - Stop bit ==1: data <= shift register; rx_valid=1 for exactly one cycle; -> IDLE immediately, without waiting out the rest of the stop bit, so back-to-back frames are caught.
  - Stop bit ==0: frame_err=1 for one cycle; data unchanged; rx_valid stays 0; -> BREAK.
- BREAK: wait until rx_s==1, then -> IDLE. rx_busy stays 1 throughout.
- Latency: rx_valid asserts on the clk edge following the stop-bit sample, i.e. 2 sync cycles + HALF_PERIOD + (W_DATA+1)*BIT_PERIOD + 1 cycles after the rx falling edge. Bench tolerance ±1 cycle.
- rx_valid and frame_err are never high in the same cycle.
- data holds its value between frames.
- Reset mid-frame: rst wins over all state; immediate return to the reset values. A partial frame is discarded.
- Counters saturate nowhere. The period counter wraps to 0 at BIT_PERIOD-1 and is cleared on every state change.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled one BIT_PERIOD after the last data bit; even parity over the data bits.
  - Adds output parity_err (1 bit, reset 0).
  - On mismatch with a good stop bit: parity_err pulses for one cycle instead of rx_valid, and data is not updated.
  - On a bad stop bit: frame_err takes priority and parity_err stays 0.
  - Latency grows by BIT_PERIOD.
- Undefined: no PARITY state and no parity_err port; frame is 1+W_DATA+1 bits.

Decomposition:
- Package uart_pkg:
  - state enum uart_rx_state_t (IDLE, START, DATA, STOP, BREAK, PARITY).
  - function bit_period(clk_freq, bitrate), shared with the transmitter.
- Sub-module uart_sync: 2-flop synchronizer with a reset value parameter (here 1), reusable for other async inputs.

Test Plan (bench parameters CLK_FREQUENCY=1_000_000, BITRATE=100_000 -> BIT_PERIOD=10):
1. Reset, rx held high for 200 cycles -> rx_valid=0, rx_busy=0, frame_err=0, data=0x00 throughout.
2. Send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) with stop=1 -> exactly one rx_valid pulse ~97 cycles after the start edge; data=0xA5; frame_err=0.
3. rx low for 3 cycles, then high -> rx_busy pulses, FSM returns to IDLE from START; no rx_valid, no frame_err.
4. Send 0x3C with stop bit 0, hold rx low 30 more cycles, then high -> one frame_err pulse; data keeps its previous value; rx_busy=1 until rx_s returns high.
5. Back-to-back 0x00 then 0xFF with zero idle bits between frames -> two rx_valid pulses with data=0x00 then 0xFF.
6. Assert rst during data bit 4 of a frame, release with rx high, then send 0x5A -> all outputs 0 after reset; next rx_valid gives data=0x5A.
